cplx_mul_pipe: RTL and testbench

//  Pipelined, parametrised signed fixed-point complex multiplier for the radix-4 FFT butterfly/twiddle path.

---
 rtl/cplx_mul_pipe.sv | 148 ++++++++++++++
 tb/tb_cplx_mul_pipe.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cplx_mul_pipe.sv
// cplx_mul_pipe
//   Three-stage pipelined signed fixed-point complex multiplier for the
//   radix-4 FFT twiddle path. Computes (a_re + j*a_im) * (b_re +/- j*b_im),
//   rescales by FRAC bits with optional round-half-up, and either clamps or
//   wraps results that do not fit in WIDTH bits.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake; in_ready is the global pipeline enable
//   in_conj           1 = multiply by conj(b)
//   a_re,a_im,b_re,b_im  signed WIDTH-bit operands
//   out_valid/out_ready  output handshake
//   out_re,out_im     signed WIDTH-bit result
//   out_ovf           result of this sample left the WIDTH range
module cplx_mul_pipe #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 31,
  parameter int ROUND    = 1,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_conj,
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] a_im,
  input  logic [WIDTH-1:0] b_re,
  input  logic [WIDTH-1:0] b_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic             out_ovf
);

  // Products and sums are carried at 2*WIDTH+2 bits so that the sum of two
  // extreme products plus the rounding constant can never overflow.
  localparam int PW = 2*WIDTH + 2;

  localparam logic signed [PW-1:0] RND  =
    (ROUND != 0) ? (PW'(1) << (FRAC-1)) : '0;
  localparam logic signed [PW-1:0] MAXV =
    {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV =
    {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic en;

  logic                    v1, v2;
  logic                    conj1;
  logic signed [WIDTH-1:0] ar1, ai1, br1, bi1;

  logic signed [WIDTH:0]   bi_ext, bip;
  logic signed [PW-1:0]    ar_x, ai_x, br_x, bip_x;

  logic signed [PW-1:0]    p_rr, p_ii, p_ri, p_ir;
  logic signed [PW-1:0]    re_full, im_full;
  logic        [WIDTH:0]   re_res, im_res;

  // A single enable stalls every stage together: the pipeline only moves
  // when the output register is empty or being drained this cycle.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage valids; bubbles move through the pipe exactly like data.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      v2 <= v1;
    end
  end

  // Stage 1 operand register.
  always_ff @(posedge clk) begin
    if (en) begin
      ar1   <= a_re;
      ai1   <= a_im;
      br1   <= b_re;
      bi1   <= b_im;
      conj1 <= in_conj;
    end
  end

  // Conjugation widens b_im by one bit first so that the most negative value
  // negates to its true positive magnitude instead of wrapping.
  assign bi_ext = {bi1[WIDTH-1], bi1};
  assign bip    = conj1 ? -bi_ext : bi_ext;

  assign ar_x  = {{(PW-WIDTH){ar1[WIDTH-1]}}, ar1};
  assign ai_x  = {{(PW-WIDTH){ai1[WIDTH-1]}}, ai1};
  assign br_x  = {{(PW-WIDTH){br1[WIDTH-1]}}, br1};
  assign bip_x = {{(PW-WIDTH-1){bip[WIDTH]}}, bip};

  // Stage 2 product register. Each product needs only 2*WIDTH bits but is
  // kept at the sum width so stage 3 needs no further extension.
  always_ff @(posedge clk) begin
    if (en) begin
      p_rr <= ar_x * br_x;
      p_ii <= ai_x * bip_x;
      p_ri <= ar_x * bip_x;
      p_ir <= ai_x * br_x;
    end
  end

  // Round, rescale and range-limit one component. Returns {ovf, value}.
  function automatic logic [WIDTH:0] scale(input logic signed [PW-1:0] full);
    logic signed [PW-1:0] sh;
    logic                 hi, lo;
    logic [WIDTH-1:0]     val;
    sh  = (full + RND) >>> FRAC;
    hi  = sh > MAXV;
    lo  = sh < MINV;
    val = sh[WIDTH-1:0];
    if (SATURATE != 0) begin
      if (hi)      val = MAXV[WIDTH-1:0];
      else if (lo) val = MINV[WIDTH-1:0];
    end
    return {hi | lo, val};
  endfunction

  assign re_full = p_rr - p_ii;
  assign im_full = p_ri + p_ir;
  assign re_res  = scale(re_full);
  assign im_res  = scale(im_full);

  // Stage 3 output register. Data is only loaded for real samples so the
  // outputs stay at zero after reset until the first result arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      out_valid <= v2;
      if (v2) begin
        out_re  <= re_res[WIDTH-1:0];
        out_im  <= im_res[WIDTH-1:0];
        out_ovf <= re_res[WIDTH] | im_res[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_cplx_mul_pipe.sv
// tb_cplx_mul_pipe
//   Self-checking bench for cplx_mul_pipe. Two instances share the same
//   stimulus: one with rounding and saturation, one truncating and wrapping.
//   Expected results come from constants and a wide-integer arithmetic model.
module tb_cplx_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_conj;
  logic [31:0] a_re, a_im, b_re, b_im;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf;
  logic [31:0] out_re, out_im;
  logic        in_ready2, out_valid2, out_ovf2;
  logic [31:0] out_re2, out_im2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        ovf;
    logic [31:0] re;
    logic [31:0] im;
  } res_t;

  typedef struct packed {
    logic [31:0] ar, ai, br, bi;
    logic        cj;
    logic [31:0] re1, im1;
    logic        ovf1;
    logic [31:0] re0, im0;
    logic        ovf0;
  } case_t;

  res_t exp_q[$];
  res_t exp2_q[$];

  cplx_mul_pipe #(.WIDTH(32), .FRAC(31), .ROUND(1), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_conj(in_conj), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re),
    .out_im(out_im), .out_ovf(out_ovf)
  );

  cplx_mul_pipe #(.WIDTH(32), .FRAC(31), .ROUND(0), .SATURATE(0)) dut_tw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_conj(in_conj), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid2), .out_ready(out_ready), .out_re(out_re2),
    .out_im(out_im2), .out_ovf(out_ovf2)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Last-resort guard in case some wait is never satisfied.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Exact complex product with wide integers, then round/shift/limit.
  function automatic res_t ref_mul(input logic [31:0] ar, ai, br, bi,
                                   input bit cj, input bit rnd, input bit sat);
    logic signed [127:0] xr, xi, yr, yi, re, im;
    logic signed [127:0] maxv, minv;
    res_t r;
    maxv = 128'sd2147483647;
    minv = -128'sd2147483648;
    xr = {{96{ar[31]}}, ar};
    xi = {{96{ai[31]}}, ai};
    yr = {{96{br[31]}}, br};
    yi = {{96{bi[31]}}, bi};
    if (cj) yi = -yi;
    re = xr * yr - xi * yi;
    im = xr * yi + xi * yr;
    if (rnd) begin
      re = re + (128'sd1 <<< 30);
      im = im + (128'sd1 <<< 30);
    end
    re = re >>> 31;
    im = im >>> 31;
    r.ovf = (re > maxv) || (re < minv) || (im > maxv) || (im < minv);
    if (sat) begin
      if (re > maxv) re = maxv; else if (re < minv) re = minv;
      if (im > maxv) im = maxv; else if (im < minv) im = minv;
    end
    r.re = re[31:0];
    r.im = im[31:0];
    return r;
  endfunction

  // Operand generator biased toward the extreme values.
  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Present one operand set for exactly one clock edge, starting at a negedge.
  task automatic applyStimulus(input logic [31:0] ar, ai, br, bi, input bit cj);
    a_re     = ar;
    a_im     = ai;
    b_re     = br;
    b_im     = bi;
    in_conj  = cj;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count cycles since the accepting edge until a result shows up (bounded).
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Reset state and in_ready right after release.
  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_conj   = 1'b0;
    out_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_valid2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid got %b/%b expected 0", out_valid, out_valid2);
    end
    checks++;
    if ({out_re, out_im, out_ovf} !== 65'd0) begin
      errors++;
      $display("[TB] FAIL reset_data got re=%h im=%h ovf=%b expected zeros", out_re, out_im, out_ovf);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  // Hand-computed cases: real, complex, conj, saturation, rounding, -b_im edge.
  task automatic test_directed();
    case_t cases[7];
    int    lat;
    cases[0] = '{32'h40000000, 32'h0, 32'h40000000, 32'h0, 1'b0,
                 32'h20000000, 32'h0, 1'b0, 32'h20000000, 32'h0, 1'b0};
    cases[1] = '{32'h40000000, 32'h40000000, 32'h40000000, 32'hC0000000, 1'b0,
                 32'h40000000, 32'h0, 1'b0, 32'h40000000, 32'h0, 1'b0};
    cases[2] = '{32'h40000000, 32'h40000000, 32'h40000000, 32'hC0000000, 1'b1,
                 32'h0, 32'h40000000, 1'b0, 32'h0, 32'h40000000, 1'b0};
    cases[3] = '{32'h80000000, 32'h0, 32'h80000000, 32'h0, 1'b0,
                 32'h7FFFFFFF, 32'h0, 1'b1, 32'h80000000, 32'h0, 1'b1};
    cases[4] = '{32'h00000001, 32'h0, 32'h40000000, 32'h0, 1'b0,
                 32'h1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
    cases[5] = '{32'hFFFFFFFF, 32'h0, 32'h40000000, 32'h0, 1'b0,
                 32'h0, 32'h0, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0};
    cases[6] = '{32'h80000000, 32'h0, 32'h0, 32'h80000000, 1'b1,
                 32'h0, 32'h80000000, 1'b0, 32'h0, 32'h80000000, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(cases[i].ar, cases[i].ai, cases[i].br, cases[i].bi, cases[i].cj);
      wait_result(lat);
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("[TB] FAIL dir%0d_latency got %0d expected 3", i, lat);
      end
      checks++;
      if ({out_ovf, out_re, out_im} !== {cases[i].ovf1, cases[i].re1, cases[i].im1}) begin
        errors++;
        $display("[TB] FAIL dir%0d_rsat got re=%h im=%h ovf=%b expected re=%h im=%h ovf=%b",
                 i, out_re, out_im, out_ovf, cases[i].re1, cases[i].im1, cases[i].ovf1);
      end
      checks++;
      if ({out_valid2, out_ovf2, out_re2, out_im2} !==
          {1'b1, cases[i].ovf0, cases[i].re0, cases[i].im0}) begin
        errors++;
        $display("[TB] FAIL dir%0d_trwrap got v=%b re=%h im=%h ovf=%b expected v=1 re=%h im=%h ovf=%b",
                 i, out_valid2, out_re2, out_im2, out_ovf2, cases[i].re0, cases[i].im0, cases[i].ovf0);
      end
    end
    @(negedge clk);
  endtask

  // Random stream with either a fixed stall window or random gaps/backpressure.
  task automatic test_stream(input string name, input int n, input int stall_at,
                             input int stall_len, input bit rand_mode);
    int          sent, got, cyc;
    bit          stalled_prev, have;
    logic [31:0] prev_re, prev_im, ar, ai, br, bi;
    bit          cj;
    res_t        e1, e2;
    sent = 0; got = 0; cyc = 0; stalled_prev = 0; have = 0;
    prev_re = '0; prev_im = '0;
    ar = '0; ai = '0; br = '0; bi = '0; cj = 0;
    exp_q.delete();
    exp2_q.delete();
    while (got < n && cyc < 400) begin
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
      else           out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (sent < n) begin
        if (!have) begin
          ar = rnd_op(); ai = rnd_op(); br = rnd_op(); bi = rnd_op();
          cj = 1'($urandom_range(0, 1));
          have = 1;
        end
        a_re = ar; a_im = ai; b_re = br; b_im = bi; in_conj = cj;
        in_valid = rand_mode ? ($urandom_range(0, 4) != 0) : 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        if (stalled_prev) begin
          checks++;
          if (out_re !== prev_re || out_im !== prev_im) begin
            errors++;
            $display("[TB] FAIL %s_stable got re=%h im=%h expected re=%h im=%h",
                     name, out_re, out_im, prev_re, prev_im);
          end
        end
        if (!out_ready) begin
          checks++;
          if (in_ready !== 1'b0 || in_ready2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_stall_ready got %b/%b expected 0", name, in_ready, in_ready2);
          end
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL %s_extra got re=%h im=%h expected no result", name, out_re, out_im);
        end else begin
          e1 = exp_q.pop_front();
          e2 = exp2_q.pop_front();
          checks++;
          if ({out_ovf, out_re, out_im} !== e1) begin
            errors++;
            $display("[TB] FAIL %s_rsat#%0d got re=%h im=%h ovf=%b expected re=%h im=%h ovf=%b",
                     name, got, out_re, out_im, out_ovf, e1.re, e1.im, e1.ovf);
          end
          checks++;
          if ({out_valid2, out_ovf2, out_re2, out_im2} !== {1'b1, e2}) begin
            errors++;
            $display("[TB] FAIL %s_trwrap#%0d got v=%b re=%h im=%h ovf=%b expected re=%h im=%h ovf=%b",
                     name, got, out_valid2, out_re2, out_im2, out_ovf2, e2.re, e2.im, e2.ovf);
          end
          got++;
        end
        stalled_prev = !out_ready;
        prev_re      = out_re;
        prev_im      = out_im;
      end else begin
        stalled_prev = 0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mul(ar, ai, br, bi, cj, 1'b1, 1'b1));
        exp2_q.push_back(ref_mul(ar, ai, br, bi, cj, 1'b0, 1'b0));
        sent++;
        have = 0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != n || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_count got %0d results expected %0d (pending %0d)",
               name, got, n, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Reset with two samples in flight, then a fresh sample.
  task automatic test_reset_midop();
    int lat, stale;
    out_ready = 1'b1;
    a_re = 32'h40000000; a_im = '0; b_re = 32'h40000000; b_im = '0;
    in_conj = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a_re = 32'h7FFFFFFF; b_re = 32'h7FFFFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_valid2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_valid got %b/%b expected 0", out_valid, out_valid2);
    end
    checks++;
    if ({out_re, out_im, out_ovf} !== 65'd0) begin
      errors++;
      $display("[TB] FAIL midrst_data got re=%h im=%h ovf=%b expected zeros", out_re, out_im, out_ovf);
    end
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || out_valid2 !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("[TB] FAIL midrst_stale got %0d stale results expected 0", stale);
    end
    applyStimulus(32'h00010000, 32'h0, 32'h00020000, 32'h0, 1'b0);
    wait_result(lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("[TB] FAIL midrst_latency got %0d expected 3", lat);
    end
    checks++;
    if ({out_ovf, out_re, out_im, out_re2} !== {1'b0, 32'd4, 32'd0, 32'd4}) begin
      errors++;
      $display("[TB] FAIL midrst_result got re=%h im=%h ovf=%b re2=%h expected re=4 im=0 ovf=0 re2=4",
               out_re, out_im, out_ovf, out_re2);
    end
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] starting cplx_mul_pipe bench");
    test_reset();
    test_directed();
    test_stream("back_to_back", 20, 0, 0, 1'b0);
    test_stream("backpressure", 8, 3, 5, 1'b0);
    test_stream("random", 40, 0, 0, 1'b1);
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
